// File: rtl/cpu_ctrl_pkg.sv
// Shared state encodings, error codes and latched decode bundle for the multi-cycle sequencer.
// Debug/trace logic decodes the state and err_code outputs with these same values.
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_CONFLICT = 2'd3;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } ctrl_t;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access; expire flags the cycle on which
// the count would reach MEM_TIMEOUT (MEM_TIMEOUT = 0 disables it).
module mem_wait_timer #(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)     cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= cnt + TIMEOUT_W'(1);
  end

  // cnt holds waits already seen, so this wait is number MEM_TIMEOUT
  assign expire = (MEM_TIMEOUT != 0) && en && (cnt == LAST);
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory port; traps on bad
// decode or memory timeout. All strobes are combinational decodes of the current state.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_ready,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic        regwrite,
  input  logic        illegal,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_load,
  output logic        pc_en,
  output logic        pc_jump,
  output logic        reg_we,
  output logic        wb_sel_mem,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt
);
  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [1:0] err_q, err_d;
  logic       retire, busy, expire;

  assign busy = (state_q == S_FETCH) || (state_q == S_MEM);

  mem_wait_timer #(.TIMEOUT_W(TIMEOUT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!busy || mem_ready),
    .en     (busy && !mem_ready),
    .expire (expire)
  );

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    err_d        = err_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_load      = 1'b0;
    pc_jump      = 1'b0;
    reg_we       = 1'b0;
    wb_sel_mem   = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (expire) begin
          state_d = S_TRAP;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_TRAP;
          err_d   = ERR_ILLEGAL;
        end else if (memread && memwrite) begin
          state_d = S_TRAP;
          err_d   = ERR_CONFLICT;
        end else begin
          ctrl_d.branch   = branch;
          ctrl_d.memread  = memread;
          ctrl_d.memwrite = memwrite;
          ctrl_d.memtoreg = memtoreg;
          ctrl_d.regwrite = regwrite;
          state_d         = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctrl_q.memread || ctrl_q.memwrite) state_d = S_MEM;
        else if (ctrl_q.regwrite)              state_d = S_WB;
        else begin
          retire  = 1'b1;
          pc_jump = ctrl_q.branch && alu_zero;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = ctrl_q.memwrite;
        if (mem_ready) begin
          if (ctrl_q.memread) state_d = S_WB;
          else                retire  = 1'b1;
        end else if (expire) begin
          state_d = S_TRAP;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_sel_mem = ctrl_q.memtoreg;
        retire     = 1'b1;
      end
      S_TRAP:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // run only matters at instruction boundaries
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  assign pc_en    = retire;
  assign err_code = err_q;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      err_q      <= ERR_NONE;
      retire_cnt <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      if (retire) retire_cnt <= retire_cnt + 32'd1;
    end
  end
endmodule
